// File: rtl/lb_sdram_fetch_pkg.sv
// -----------------------------------------------------------------------------
// lb_pkg
//   Shared types and constants for the line-buffer fetch engine.
//   - lb_state_e   : fetch engine state (IDLE, FETCH)
//   - WORD_W       : SDRAM word width (8 RGB565 pixels)
//   - PIX_W        : pixel width
//   - PIX_PER_WORD : pixels packed in one SDRAM word
//   - ADDR_W       : SDRAM word address width
//   - lane_select  : extracts one pixel from a packed word (lane 0 = LSBs)
// -----------------------------------------------------------------------------
package lb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } lb_state_e;

  localparam int WORD_W       = 128;
  localparam int PIX_W        = 16;
  localparam int PIX_PER_WORD = 8;
  localparam int ADDR_W       = 22;

  // Lane k occupies bits [16k+15 : 16k]; {lane, 4'b0} is 16*lane.
  function automatic logic [PIX_W-1:0] lane_select(input logic [WORD_W-1:0] word,
                                                   input logic [2:0]        lane);
    return word[{lane, 4'b0000} +: PIX_W];
  endfunction

endpackage

// File: rtl/lb_sdram_fetch_ram.sv
// -----------------------------------------------------------------------------
// lb_ram
//   Simple dual-port line buffer memory: one synchronous write port, one
//   synchronous read port with registered output. No reset on the array or
//   the read register so the memory maps onto block RAM.
//   Ports:
//     clk      in   clock
//     we_i     in   write enable
//     waddr_i  in   write address
//     wdata_i  in   write data
//     raddr_i  in   read address (sampled every cycle)
//     rdata_o  out  read data, one cycle after raddr_i
// -----------------------------------------------------------------------------
module lb_ram
  import lb_pkg::*;
#(
  parameter int DEPTH = 160,
  parameter int AW    = 8,
  parameter int DW    = WORD_W
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/lb_sdram_fetch.sv
// -----------------------------------------------------------------------------
// lb_sdram_fetch
//   Read-side client of the SDRAM arbiter. Once per scanline (when DrawX hits
//   TRIGGER_X) it fetches display line (DrawY+2) mod V_TOTAL as WORDS_PER_LINE
//   128-bit words into one bank of a ping-pong line buffer, while the VGA path
//   reads pixels for the current line out of the other bank.
//
//   Build option: define LB_UNDERRUN_CNT_EN to count aborted (late) line
//   fetches in underrun_cnt; otherwise underrun_cnt is tied to zero.
//
//   Ports:
//     clk            in   system clock
//     reset          in   asynchronous active-high reset
//     new_frame      in   one-cycle frame-start pulse, clears lb_done
//     DrawX, DrawY   in   current pixel column / row
//     lb_sdram_rd    out  read request (FETCH and not Wait)
//     lb_sdram_addr  out  SDRAM word address, held until acknowledged
//     lb_sdram_Wait  in   arbiter withholds grant
//     lb_sdram_ac    in   one-cycle acknowledge, lb_sdram_data valid
//     lb_sdram_data  in   read data
//     lb_Busy        out  a line fetch is in progress
//     lb_done        out  last visible line of the frame has been fetched
//     pixel          out  RGB565 pixel for the previous-cycle DrawX/DrawY
//     underrun_cnt   out  number of aborted line fetches (saturating)
// -----------------------------------------------------------------------------
module lb_sdram_fetch
  import lb_pkg::*;
#(
  parameter logic [ADDR_W-1:0] FB_BASE        = 22'h000000,
  parameter int                WORDS_PER_LINE = 80,
  parameter int                H_ACTIVE       = 640,
  parameter int                V_ACTIVE       = 480,
  parameter int                V_TOTAL        = 525,
  parameter int                TRIGGER_X      = 799
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              new_frame,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic              lb_sdram_rd,
  output logic [ADDR_W-1:0] lb_sdram_addr,
  input  logic              lb_sdram_Wait,
  input  logic              lb_sdram_ac,
  input  logic [WORD_W-1:0] lb_sdram_data,
  output logic              lb_Busy,
  output logic              lb_done,
  output logic [PIX_W-1:0]  pixel,
  output logic [15:0]       underrun_cnt
);

  localparam int RAM_DEPTH = 2 * WORDS_PER_LINE;
  localparam int RAM_AW    = $clog2(RAM_DEPTH);

  // ---------------------------------------------------------------------------
  // Fetch engine state
  // ---------------------------------------------------------------------------
  lb_state_e         state_q;
  logic [9:0]        tgt_q;
  logic [6:0]        word_idx_q;
  logic [ADDR_W-1:0] addr_q;
  logic              done_q;
  logic              trig_seen_q;

  // ---------------------------------------------------------------------------
  // Trigger and target line
  // ---------------------------------------------------------------------------
  logic              trig_hit;
  logic              trigger;
  logic              abort;
  logic [10:0]       y_plus2;
  logic [9:0]        tgt_d;
  logic              tgt_valid;
  logic [16:0]       line_off;
  logic [ADDR_W-1:0] line_base;
  logic              last_word;
  logic              done_set;

  // DrawX may sit on TRIGGER_X for several system clocks when the pixel clock
  // is slower, so only the first cycle of that column launches a fetch;
  // otherwise the repeat would look like a late line and abort the fetch.
  assign trig_hit = (DrawX == 10'(TRIGGER_X));
  assign trigger  = trig_hit & ~trig_seen_q;

  // DrawY+2 never exceeds 2*V_TOTAL, so one conditional subtract is the modulo.
  assign y_plus2   = {1'b0, DrawY} + 11'd2;
  assign tgt_d     = (y_plus2 >= 11'(V_TOTAL)) ? 10'(y_plus2 - 11'(V_TOTAL)) : y_plus2[9:0];
  assign tgt_valid = (tgt_d < 10'(V_ACTIVE));

  // Line offset is a 17-bit product, zero-extended before adding the base.
  assign line_off  = 17'(tgt_d) * 17'(WORDS_PER_LINE);
  assign line_base = FB_BASE + {{(ADDR_W-17){1'b0}}, line_off};

  assign abort     = (state_q == FETCH) & trigger;
  assign last_word = (word_idx_q == 7'(WORDS_PER_LINE - 1));
  assign done_set  = (state_q == FETCH) & ~trigger & lb_sdram_ac & last_word &
                     (tgt_q == 10'(V_ACTIVE - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      tgt_q       <= '0;
      word_idx_q  <= '0;
      addr_q      <= '0;
      done_q      <= 1'b0;
      trig_seen_q <= 1'b0;
    end else begin
      trig_seen_q <= trig_hit;

      // A frame-start pulse coinciding with the final acknowledge wins.
      if (new_frame) begin
        done_q <= 1'b0;
      end else if (done_set) begin
        done_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (trigger && tgt_valid) begin
            state_q    <= FETCH;
            tgt_q      <= tgt_d;
            word_idx_q <= '0;
            addr_q     <= line_base;
          end
        end

        FETCH: begin
          if (abort) begin
            // Late line: the next trigger arrived before the last word.
            // Restart on the new line; the old bank keeps partial data.
            if (tgt_valid) begin
              tgt_q      <= tgt_d;
              word_idx_q <= '0;
              addr_q     <= line_base;
            end else begin
              state_q <= IDLE;
            end
          end else if (lb_sdram_ac) begin
            // Acknowledge is honoured even if Wait rose this same cycle.
            word_idx_q <= word_idx_q + 7'd1;
            addr_q     <= addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            if (last_word) begin
              state_q <= IDLE;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // Request follows Wait combinationally; the address register only moves on
  // an acknowledge, so a withdrawn request re-issues the same word.
  assign lb_sdram_rd   = (state_q == FETCH) & ~lb_sdram_Wait;
  assign lb_sdram_addr = addr_q;
  assign lb_Busy       = (state_q == FETCH);
  assign lb_done       = done_q;

  // ---------------------------------------------------------------------------
  // Ping-pong line buffer: bank b occupies words [b*WORDS_PER_LINE +: WORDS_PER_LINE]
  // ---------------------------------------------------------------------------
  logic              ram_we;
  logic [RAM_AW-1:0] ram_waddr;
  logic [RAM_AW-1:0] ram_raddr;
  logic [WORD_W-1:0] ram_rdata;
  logic [6:0]        rd_word;

  assign ram_we    = (state_q == FETCH) & lb_sdram_ac;
  assign ram_waddr = tgt_q[0] ? RAM_AW'(WORDS_PER_LINE) + RAM_AW'(word_idx_q)
                              : RAM_AW'(word_idx_q);

  assign rd_word = DrawX[9:3];

  // Columns past the buffer read word 0; the pixel is blanked anyway.
  always_comb begin
    ram_raddr = '0;
    if (rd_word < 7'(WORDS_PER_LINE)) begin
      ram_raddr = DrawY[0] ? RAM_AW'(WORDS_PER_LINE) + RAM_AW'(rd_word)
                           : RAM_AW'(rd_word);
    end
  end

  lb_ram #(
    .DEPTH (RAM_DEPTH),
    .AW    (RAM_AW),
    .DW    (WORD_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (lb_sdram_data),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // ---------------------------------------------------------------------------
  // Pixel path: lane and visibility are registered alongside the RAM read so
  // the lane mux lines up with the RAM output one cycle after DrawX/DrawY.
  // ---------------------------------------------------------------------------
  logic [2:0] lane_q;
  logic       vis_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q <= '0;
      vis_q  <= 1'b0;
    end else begin
      lane_q <= DrawX[2:0];
      vis_q  <= (DrawX < 10'(H_ACTIVE)) && (DrawY < 10'(V_ACTIVE));
    end
  end

  assign pixel = vis_q ? lane_select(ram_rdata, lane_q) : '0;

  // ---------------------------------------------------------------------------
  // Late-line counter
  // ---------------------------------------------------------------------------
`ifdef LB_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underrun_cnt_q <= '0;
    end else if (abort && (underrun_cnt_q != 16'hFFFF)) begin
      underrun_cnt_q <= underrun_cnt_q + 16'd1;
    end
  end

  assign underrun_cnt = underrun_cnt_q;
`else
  assign underrun_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_lb_sdram_fetch.sv
// -----------------------------------------------------------------------------
// tb_lb_sdram_fetch
//   Self-checking bench for lb_sdram_fetch. A small arbiter model answers
//   requests; a reference model keeps the expected line, word position,
//   bank contents, lb_done and late-line count from the fetch rules.
// -----------------------------------------------------------------------------
module tb_lb_sdram_fetch;

  localparam int          WPL      = 80;
  localparam int          H_ACT    = 640;
  localparam int          V_ACT    = 480;
  localparam int          V_TOT    = 525;
  localparam int          TRIG_X   = 799;
  localparam logic [21:0] BASE     = 22'h000000;

  logic         clk = 1'b0;
  logic         reset;
  logic         new_frame;
  logic [9:0]   DrawX;
  logic [9:0]   DrawY;
  logic         lb_sdram_rd;
  logic [21:0]  lb_sdram_addr;
  logic         lb_sdram_Wait;
  logic         lb_sdram_ac;
  logic [127:0] lb_sdram_data;
  logic         lb_Busy;
  logic         lb_done;
  logic [15:0]  pixel;
  logic [15:0]  underrun_cnt;

  always #5 clk = ~clk;

  lb_sdram_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .new_frame     (new_frame),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .lb_sdram_rd   (lb_sdram_rd),
    .lb_sdram_addr (lb_sdram_addr),
    .lb_sdram_Wait (lb_sdram_Wait),
    .lb_sdram_ac   (lb_sdram_ac),
    .lb_sdram_data (lb_sdram_data),
    .lb_Busy       (lb_Busy),
    .lb_done       (lb_done),
    .pixel         (pixel),
    .underrun_cnt  (underrun_cnt)
  );

  // Reference model state
  bit           m_busy;
  int           m_line;
  int           m_word;
  bit           m_done;
  int           m_under;
  logic [127:0] m_bank [2][WPL];
  bit           pattern_mode;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          x;
    int          y;
    logic [15:0] exp;
  } pix_vec_t;

  pix_vec_t tbl[12];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (line %0d word %0d, t=%0t)",
               name, act, exp, m_line, m_word, $time);
    end
  endtask

  function automatic logic [15:0] exp_under();
`ifdef LB_UNDERRUN_CNT_EN
    return (m_under > 65535) ? 16'hFFFF : 16'(m_under);
`else
    return 16'h0000;
`endif
  endfunction

  function automatic logic [15:0] exp_pix(input int x, input int y);
    logic [127:0] w;
    if (x >= H_ACT || y >= V_ACT) return 16'h0000;
    w = m_bank[y % 2][x / 8];
    return w[16*(x % 8) +: 16];
  endfunction

  // Line 0 pattern: word 2 lane k = k, every other word lane k = word*256+k.
  function automatic logic [127:0] make_data(input int word);
    logic [127:0] d;
    if (pattern_mode) begin
      for (int k = 0; k < 8; k++)
        d[16*k +: 16] = (word == 2) ? 16'(k) : 16'(word * 256 + k);
    end else begin
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    return d;
  endfunction

  // One arbiter-side clock: drive Wait/ac/new_frame, check the request side,
  // advance one edge, then check the registered status outputs.
  task automatic bus_cycle(input bit wt, input bit give_ac, input bit nf);
    logic [127:0] d;
    bit           last;
    lb_sdram_Wait = wt;
    new_frame     = nf;
    #1;
    chk("rd", lb_sdram_rd, m_busy && !wt);
    if (m_busy) chk("addr", lb_sdram_addr, 22'(int'(BASE) + m_line * WPL + m_word));
    last = 1'b0;
    if (give_ac && m_busy) begin
      d             = make_data(m_word);
      lb_sdram_ac   = 1'b1;
      lb_sdram_data = d;
      m_bank[m_line % 2][m_word] = d;
      m_word++;
      if (m_word == WPL) begin
        m_busy = 1'b0;
        last   = (m_line == V_ACT - 1);
      end
    end
    @(posedge clk); #1;
    lb_sdram_ac = 1'b0;
    new_frame   = 1'b0;
    if (nf) m_done = 1'b0;
    else if (last) m_done = 1'b1;
    chk("busy", lb_Busy, m_busy);
    chk("done", lb_done, m_done);
    chk("underrun", underrun_cnt, exp_under());
  endtask

  task automatic trigger(input int y);
    int t;
    DrawY = 10'(y);
    DrawX = 10'(TRIG_X);
    t = (y + 2) % V_TOT;
    @(posedge clk); #1;
    DrawX = 10'd0;
    if (m_busy) m_under++;
    if (t < V_ACT) begin
      m_busy = 1'b1;
      m_line = t;
      m_word = 0;
    end else begin
      m_busy = 1'b0;
    end
    chk("trig_busy", lb_Busy, m_busy);
    chk("trig_underrun", underrun_cnt, exp_under());
  endtask

  // mode 0: ac every 3rd cycle; 1: random Wait/ac; 2: Wait hold at word 17 and
  // ac+Wait together at word 40; 3: ac every 3rd with new_frame on the last ac.
  task automatic run_fetch(input int mode);
    int cyc;
    bit did17, did40, ac_v, nf_v;
    cyc = 0; did17 = 0; did40 = 0;
    while (m_busy && cyc < 3000) begin
      cyc++;
      if (mode == 2 && m_word == 17 && !did17) begin
        did17 = 1;
        bus_cycle(0, 0, 0);
        repeat (5) bus_cycle(1, 0, 0);
      end else if (mode == 2 && m_word == 40 && !did40) begin
        did40 = 1;
        bus_cycle(0, 0, 0);
        bus_cycle(1, 1, 0);
        bus_cycle(1, 0, 0);
        bus_cycle(1, 0, 0);
      end else if (mode == 1) begin
        bus_cycle($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, 0);
      end else begin
        ac_v = (cyc % 3 == 0);
        nf_v = (mode == 3) && ac_v && (m_word == WPL - 1);
        bus_cycle(0, ac_v, nf_v);
      end
    end
    if (m_busy) begin
      n_vec++; n_err++;
      $display("FAIL fetch_timeout: line %0d stuck at word %0d, required %0d words", m_line, m_word, WPL);
      m_busy = 1'b0;
    end else begin
      $display("fetch line %0d complete (mode %0d, %0d cycles)", m_line, mode, cyc);
    end
  endtask

  task automatic check_line(input int y, input int n);
    int x;
    for (int i = 0; i < n; i++) begin
      x = $urandom_range(0, H_ACT - 1);
      DrawY = 10'(y);
      DrawX = 10'(x);
      @(posedge clk); #1;
      chk("pixel", pixel, exp_pix(x, y));
    end
    DrawX = 10'd0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    int y;
    reset = 1'b1; new_frame = 1'b0; DrawX = 10'd0; DrawY = 10'd0;
    lb_sdram_Wait = 1'b0; lb_sdram_ac = 1'b0; lb_sdram_data = '0;
    m_busy = 0; m_line = 0; m_word = 0; m_done = 0; m_under = 0; pattern_mode = 0;

    for (int k = 0; k < 8; k++) tbl[k] = '{16 + k, 0, 16'(k)};
    tbl[8]  = '{640, 0, 16'h0000};
    tbl[9]  = '{9,   0, 16'h0101};
    tbl[10] = '{639, 0, 16'h4F07};
    tbl[11] = '{16,  480, 16'h0000};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd", lb_sdram_rd, 0);
    chk("rst_addr", lb_sdram_addr, 0);
    chk("rst_busy", lb_Busy, 0);
    chk("rst_done", lb_done, 0);
    chk("rst_pixel", pixel, 0);
    chk("rst_underrun", underrun_cnt, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Line 12 with a steady ac every 3rd cycle
    trigger(10);
    run_fetch(0);
    check_line(12, 24);

    // Line 22 with a Wait hold at word 17 and ac+Wait at word 40
    trigger(20);
    run_fetch(2);
    check_line(22, 40);

    // Random lines with random Wait/ac timing
    for (int i = 0; i < 5; i++) begin
      y = $urandom_range(0, 470);
      trigger(y);
      run_fetch(1);
      check_line(y + 2, 16);
    end

    // Lines 0 and 1 are fetched from the last two rows of the frame
    pattern_mode = 1;
    trigger(V_TOT - 2);
    run_fetch(1);
    pattern_mode = 0;
    trigger(V_TOT - 1);
    run_fetch(1);
    for (int i = 0; i < 12; i++) begin
      DrawY = 10'(tbl[i].y);
      DrawX = 10'(tbl[i].x);
      @(posedge clk); #1;
      chk("pix_table", pixel, tbl[i].exp);
      $display("vector %0d: x=%0d y=%0d pixel=%h", i, tbl[i].x, tbl[i].y, pixel);
    end
    DrawX = 10'd0;
    check_line(1, 24);

    // Last visible line sets lb_done; rows 478/479 launch nothing
    trigger(V_ACT - 3);
    run_fetch(1);
    chk("done_after_479", lb_done, 1);
    trigger(V_ACT - 2);
    repeat (4) bus_cycle(0, 0, 0);
    trigger(V_ACT - 1);
    repeat (4) bus_cycle(0, 0, 0);
    bus_cycle(0, 0, 1);
    chk("done_cleared", lb_done, 0);

    // new_frame on the final ac: clear wins
    trigger(V_ACT - 3);
    run_fetch(3);
    chk("done_nf_wins", lb_done, 0);

    // Late line: ac held low through the next trigger
    trigger(40);
    for (int i = 0; i < 12; i++) bus_cycle(0, (i % 2) == 0, 0);
    repeat (4) bus_cycle(0, 0, 0);
    trigger(41);
    chk("restart_line", 32'(m_line), 43);
    run_fetch(1);
    check_line(43, 16);

    // Asynchronous reset in the middle of a fetch
    trigger(60);
    repeat (3) bus_cycle(0, 0, 0);
    reset = 1'b1;
    #1;
    chk("arst_rd", lb_sdram_rd, 0);
    chk("arst_busy", lb_Busy, 0);
    chk("arst_addr", lb_sdram_addr, 0);
    chk("arst_underrun", underrun_cnt, 0);
    m_busy = 0; m_done = 0; m_under = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) bus_cycle(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
